// File: rtl/bcd_mmss_timer.sv
// MM:SS BCD countdown timer with keypad entry, start/pause/clear and 7-segment decode.
// Optional alarm phase in DONE is enabled by defining TIMER_ALARM_EN.
module bcd_mmss_timer #(
   parameter int unsigned TICK_DIV     = 50_000_000,
   parameter int unsigned MAX_MIN_TENS = 9,
   parameter int unsigned ALARM_SECS   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] in,
   input  logic       start,
   input  logic       stop,
   output logic [3:0] sec_unit,
   output logic [3:0] sec_tens,
   output logic [3:0] min_unit,
   output logic [3:0] min_tens,
   output logic [6:0] seg_sec_unit,
   output logic [6:0] seg_sec_tens,
   output logic [6:0] seg_min_unit,
   output logic [6:0] seg_min_tens,
   output logic       running,
   output logic       paused,
   output logic       finished,
   output logic       err
`ifdef TIMER_ALARM_EN
   ,
   output logic       alarm
`endif
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);
   localparam logic [3:0] MaxMinTens = 4'(MAX_MIN_TENS);

   typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

   state_e        state_q;
   logic [15:0]   time_q;   // {min_tens, min_unit, sec_tens, sec_unit}
   logic [PW-1:0] presc_q;
   logic          err_q;

   logic          tick;
   logic          digit_ok;
   logic          start_ok;
   logic [15:0]   time_shift;
   logic [15:0]   time_dec;
   logic          dec_zero;

`ifdef TIMER_ALARM_EN
   localparam int unsigned AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
   localparam logic [AW-1:0] AlarmLast = AW'(ALARM_SECS - 1);
   logic          alarm_q;
   logic [AW-1:0] acnt_q;
   assign alarm = alarm_q;
`endif

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   assign tick       = (presc_q == PrescMax);
   assign digit_ok   = (in <= 4'd9);
   assign start_ok   = (time_q[7:4] <= 4'd5) && (time_q[15:12] <= MaxMinTens) &&
                       (time_q != 16'h0000);
   assign time_shift = {time_q[11:0], in};

   // One-second borrow chain; only used while the time is nonzero.
   always_comb begin
      time_dec = {time_q[15:4], time_q[3:0] - 4'd1};
      if (time_q[3:0] == 4'd0) begin
         time_dec[3:0] = 4'd9;
         time_dec[7:4] = time_q[7:4] - 4'd1;
         if (time_q[7:4] == 4'd0) begin
            time_dec[7:4]  = 4'd5;
            time_dec[11:8] = time_q[11:8] - 4'd1;
            if (time_q[11:8] == 4'd0) begin
               time_dec[11:8]  = 4'd9;
               time_dec[15:12] = time_q[15:12] - 4'd1;
            end
         end
      end
   end

   assign dec_zero = (time_dec == 16'h0000);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         time_q  <= '0;
         presc_q <= '0;
         err_q   <= 1'b0;
`ifdef TIMER_ALARM_EN
         alarm_q <= 1'b0;
         acnt_q  <= '0;
`endif
      end else begin
         err_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (stop) begin
                  time_q <= '0;
               end else if (start) begin
                  if (start_ok) begin
                     state_q <= StRun;
                     presc_q <= '0;
                  end else begin
                     err_q <= 1'b1;
                  end
               end else if (load) begin
                  if (digit_ok) time_q <= time_shift;
                  else          err_q  <= 1'b1;
               end
            end
            StRun: begin
               if (stop) begin
                  // The cycle ending at the stop edge was a running cycle, so it still counts,
                  // but a wrap is deferred so the pending tick fires right after resume.
                  state_q <= StPause;
                  if (!tick) presc_q <= presc_q + PW'(1);
               end else if (tick) begin
                  presc_q <= '0;
                  time_q  <= time_dec;
                  if (dec_zero) begin
                     state_q <= StDone;
`ifdef TIMER_ALARM_EN
                     alarm_q <= 1'b1;
                     acnt_q  <= '0;
`endif
                  end
               end else begin
                  presc_q <= presc_q + PW'(1);
               end
            end
            StPause: begin
               if (stop) begin
                  state_q <= StIdle;
                  time_q  <= '0;
               end else if (start) begin
                  state_q <= StRun;
               end
            end
            StDone: begin
               if (stop || start) begin
                  state_q <= StIdle;
`ifdef TIMER_ALARM_EN
                  alarm_q <= 1'b0;
`endif
               end else if (load) begin
                  state_q <= StIdle;
                  if (digit_ok) time_q <= time_shift;
                  else          err_q  <= 1'b1;
`ifdef TIMER_ALARM_EN
                  alarm_q <= 1'b0;
               end else if (tick) begin
                  presc_q <= '0;
                  if (acnt_q == AlarmLast) begin
                     state_q <= StIdle;
                     alarm_q <= 1'b0;
                  end else begin
                     acnt_q <= acnt_q + AW'(1);
                  end
               end else begin
                  presc_q <= presc_q + PW'(1);
`endif
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign sec_unit = time_q[3:0];
   assign sec_tens = time_q[7:4];
   assign min_unit = time_q[11:8];
   assign min_tens = time_q[15:12];

   assign seg_sec_unit = seg7(time_q[3:0]);
   assign seg_sec_tens = seg7(time_q[7:4]);
   assign seg_min_unit = seg7(time_q[11:8]);
   assign seg_min_tens = seg7(time_q[15:12]);

   assign running  = (state_q == StRun);
   assign paused   = (state_q == StPause);
   assign finished = (state_q == StDone);
   assign err      = err_q;

endmodule

// File: doc/bcd_mmss_timer.md
# bcd_mmss_timer

Parametrised MM:SS countdown timer with keypad-style digit entry, start/pause/clear control, and a done indication. Four BCD digits are each decoded to a 7-segment output. The block sits between the keypad/button debouncers and the display/magnetron control. It is the next generation of the single-shot down-counter chain, adding pause/resume, input validation and a configurable time base.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clk cycles per one-second tick. Must be ≥ 2.
- `MAX_MIN_TENS`, default 9: largest legal minutes-tens digit (0–9).
- `ALARM_SECS`, default 3: length of the alarm phase in ticks. Used only with `TIMER_ALARM_EN`.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-low reset.
- `load`  in  1: digit-entry strobe, one cycle per digit.
- `in`  in  4: BCD digit presented with `load`.
- `start`  in  1: start/resume strobe.
- `stop`  in  1: pause/clear strobe.
- `sec_unit`, `sec_tens`, `min_unit`, `min_tens`  out  4 each: registered BCD digits.
- `seg_sec_unit`, `seg_sec_tens`, `seg_min_unit`, `seg_min_tens`  out  7 each:
  - bit order {g,f,e,d,c,b,a}; 1 = segment lit;
  - combinational decode of the digit registers;
  - codes 10–15 decode to blank.
- `running`  out  1: state is RUN.
- `paused`  out  1: state is PAUSE.
- `finished`  out  1: state is DONE.
- `err`  out  1: one-cycle pulse when a strobe is rejected.
- `alarm`  out  1: alarm phase active. Present only with `TIMER_ALARM_EN`.

## Operation
- States: IDLE, RUN, PAUSE, DONE. The status outputs (`running`, `paused`, `finished`) decode the state register.
- Reset (`rst`=0 at a clock edge):
  - state IDLE; all digits 0; prescaler 0;
  - `running`, `paused`, `finished`, `err`, `alarm` all 0;
  - every seg output = 0111111.
- Digit entry (IDLE only):
  - `load` with `in` ≤ 9 shifts left: `min_tens`←`min_unit`, `min_unit`←`sec_tens`, `sec_tens`←`sec_unit`, `sec_unit`←`in`.
  - `in` > 9 is ignored and pulses `err`.
  - Digits are not range-checked during entry.
  - `load` in RUN or PAUSE is ignored, with no `err`.
- IDLE + `start`:
  - Accepted if `sec_tens` ≤ 5, `min_tens` ≤ `MAX_MIN_TENS`, and the time is nonzero. Then go to RUN with the prescaler cleared.
  - Otherwise stay in IDLE and pulse `err`.
- RUN:
  - The prescaler counts 0…`TICK_DIV`−1. On reaching `TICK_DIV`−1 it wraps to 0 and the time decrements by one second.
  - Borrow chain: `sec_unit` 0→9 borrows; `sec_tens` 0→5 borrows; `min_unit` 0→9 borrows; `min_tens` decrements.
  - A decrement that reaches 00:00 moves the state to DONE on the same edge.
- RUN + `stop` → PAUSE. Digits and prescaler are frozen.
- PAUSE + `start` → RUN. The prescaler resumes from its held value.
- PAUSE + `stop` → IDLE with digits cleared to 0.
- IDLE + `stop` → digits cleared to 0.
- DONE exit (without `TIMER_ALARM_EN`): DONE is held until a strobe arrives.
  - `start` or `stop` → IDLE, digits remain 0.
  - `load` → IDLE and the digit shift is applied on the same edge.
- Priority:
  - `stop` beats `start` in the same cycle.
  - A `stop` arriving on the tick edge in RUN wins: no decrement occurs and the state goes to PAUSE.
  - `load` together with `start`/`stop` in IDLE: `stop` (clear) beats `start` beats `load`.
- `rst` asserted mid-run overrides everything and applies the reset values on that edge.

## Timing
- All state, digits, prescaler, `err` and `alarm` are registered.
- Seg outputs follow the digit registers with zero cycles of latency.
- Accepted `start` (edge N): `running`=1 from edge N. The first decrement occurs at edge N+`TICK_DIV`.
- A resumed run continues the partial second: no tick is lost and no tick is doubled.
- The final decrement to 00:00 at edge M: `finished`=1 and `running`=0 from edge M.
- `err` is high for exactly the one cycle after the rejected strobe's edge.

## Configuration
- Macro: `TIMER_ALARM_EN`.
- Defined:
  - the `alarm` port exists;
  - DONE runs the prescaler;
  - `alarm`=1 for the first `ALARM_SECS` ticks in DONE;
  - at the end of the last alarm tick the state returns to IDLE automatically and `alarm`, `finished` drop on that edge;
  - strobes during DONE behave as in the non-macro build and clear `alarm`.
- Undefined:
  - no `alarm` port and no alarm logic;
  - DONE holds indefinitely until a strobe.

## Test plan
All scenarios use `TICK_DIV`=4.
- Load 1, 3, 0 → digits 01:30; `seg_min_unit`=0000110; `seg_sec_tens`=1001111.
- Load 2 then `start` → `running` next edge; `sec_unit`=1 after 4 cycles, 0 after 8; `finished`=1 and `running`=0 on that edge.
- Load 1,0,0 and start → after one tick digits read 00:59; after 60 ticks `finished`=1.
- Run 00:05:
  - `stop` 2 cycles after a tick → `paused`=1, digits frozen 12 cycles;
  - `start` → next decrement 2 cycles later;
  - `stop` twice → IDLE, 00:00.
- `start` at 00:00 → `err` pulse, IDLE.
- Load 7,5 then `start` (00:75) → `err` pulse, no run.
- Load `in`=12 → `err` pulse, digits unchanged.
- With `TIMER_ALARM_EN`, `ALARM_SECS`=2, time 00:01 → DONE; `alarm`=1 for 8 cycles; then IDLE with `finished`=0, `alarm`=0.
